// File: rtl/truth_table_sequencer.sv
// Truth-table sequencer: steps a 3-input combinational block through all
// eight input vectors, waits SETTLE cycles per vector, samples f, and
// compares the captured table against a latched golden table.
module truth_table_sequencer #(
   parameter int unsigned SETTLE = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic [7:0] expected,
   input  logic       f,
   output logic       x1,
   output logic       x2,
   output logic       x3,
   output logic       busy,
   output logic       done,
   output logic [7:0] table_out,
   output logic       mismatch,
   output logic [2:0] err_index
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRIVE,
      S_SAMPLE,
      S_DONE
   } state_e;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

   state_e     state_q, state_d;
   logic [2:0] idx_q, idx_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] exp_q, exp_d;
   logic [7:0] work_q, work_d;
   logic [7:0] table_q, table_d;
   logic       mismatch_q, mismatch_d;
   logic [2:0] err_q, err_d;

   logic [7:0] final_tbl;
   logic [7:0] diff;
   logic [2:0] first_diff;

   // Completed table as it will look after the current sample, and its
   // lowest differing bit against the latched golden table.
   always_comb begin
      final_tbl        = work_q;
      final_tbl[idx_q] = f;
      diff             = final_tbl ^ exp_q;
      first_diff       = '0;
      for (int unsigned i = 8; i > 0; i--) begin
         if (diff[i-1]) first_diff = 3'(i - 1);
      end
   end

   // Next-state and datapath updates; abort takes priority over sampling.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      exp_d      = exp_q;
      work_d     = work_q;
      table_d    = table_q;
      mismatch_d = mismatch_q;
      err_d      = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               exp_d   = expected;
               idx_d   = '0;
               cnt_d   = '0;
               work_d  = '0;
               state_d = S_DRIVE;
            end
         end
         S_DRIVE: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (cnt_q == SETTLE_LAST) begin
               state_d = S_SAMPLE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_SAMPLE: begin
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               work_d = final_tbl;
               if (idx_q == 3'd7) begin
                  table_d    = final_tbl;
                  mismatch_d = |diff;
                  err_d      = first_diff;
                  state_d    = S_DONE;
               end else begin
                  idx_d   = idx_q + 3'd1;
                  cnt_d   = '0;
                  state_d = S_DRIVE;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         cnt_q      <= '0;
         exp_q      <= '0;
         work_q     <= '0;
         table_q    <= '0;
         mismatch_q <= 1'b0;
         err_q      <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         exp_q      <= exp_d;
         work_q     <= work_d;
         table_q    <= table_d;
         mismatch_q <= mismatch_d;
         err_q      <= err_d;
      end
   end

   // Moore outputs decoded from the state register.
   always_comb begin
      busy         = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
      done         = (state_q == S_DONE);
      {x1, x2, x3} = busy ? idx_q : 3'b000;
   end

   assign table_out = table_q;
   assign mismatch  = mismatch_q;
   assign err_index = err_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Self-checking bench: three sequencers (SETTLE = 1, 2, 15) share stimulus;
// a cycle-level reference derived from sweep timing rules checks them.
module tb_truth_table_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       start;
   logic       abort;
   logic [7:0] expected;
   logic [7:0] func_tbl;

   logic [2:0][2:0] xv;
   logic [2:0]      f;
   logic [2:0]      busy;
   logic [2:0]      done;
   logic [2:0][7:0] tbl;
   logic [2:0]      mm;
   logic [2:0][2:0] ei;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] prev_tbl;
   logic       prev_mm;
   logic [2:0] prev_ei;

   // The block under control: an arbitrary 3-input function as a lookup.
   assign f[0] = func_tbl[xv[0]];
   assign f[1] = func_tbl[xv[1]];
   assign f[2] = func_tbl[xv[2]];

   truth_table_sequencer #(.SETTLE(1)) u_s1 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .expected(expected), .f(f[0]),
      .x1(xv[0][2]), .x2(xv[0][1]), .x3(xv[0][0]),
      .busy(busy[0]), .done(done[0]), .table_out(tbl[0]),
      .mismatch(mm[0]), .err_index(ei[0]));

   truth_table_sequencer #(.SETTLE(2)) u_s2 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .expected(expected), .f(f[1]),
      .x1(xv[1][2]), .x2(xv[1][1]), .x3(xv[1][0]),
      .busy(busy[1]), .done(done[1]), .table_out(tbl[1]),
      .mismatch(mm[1]), .err_index(ei[1]));

   truth_table_sequencer #(.SETTLE(15)) u_s15 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .expected(expected), .f(f[2]),
      .x1(xv[2][2]), .x2(xv[2][1]), .x3(xv[2][0]),
      .busy(busy[2]), .done(done[2]), .table_out(tbl[2]),
      .mismatch(mm[2]), .err_index(ei[2]));

   function automatic int settle_of(input int i);
      return (i == 0) ? 1 : (i == 1) ? 2 : 15;
   endfunction

   // Lowest index where the two tables disagree, 0 when equal.
   function automatic logic [2:0] ref_err(input logic [7:0] a, input logic [7:0] b);
      for (int k = 0; k < 8; k++) begin
         if (a[k] != b[k]) return 3'(k);
      end
      return 3'd0;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_x"},     32'(xv),   32'd0);
      check({tag, "_flags"}, 32'({busy, done, mm}), 32'd0);
      check({tag, "_table"}, 32'(tbl),  32'd0);
      check({tag, "_err"},   32'(ei),   32'd0);
   endtask

   // One sweep: abort_at / rst_at are edge counts after the start edge
   // (negative = unused); rand_start toggles start while busy.
   task automatic sweep(input logic [7:0] exp_v, input int abort_at,
                        input int rst_at, input bit rand_start);
      int         done_at [3];
      int         bad     [3];
      bit         stop;
      logic [7:0] new_tbl;
      logic       new_mm;
      logic [2:0] new_ei;
      new_tbl = func_tbl;
      new_mm  = (func_tbl != exp_v);
      new_ei  = ref_err(func_tbl, exp_v);
      for (int i = 0; i < 3; i++) begin
         done_at[i] = -1;
         bad[i]     = 0;
      end
      stop = 1'b0;
      @(negedge clk);
      expected = exp_v;
      start    = 1'b1;
      @(posedge clk);
      #1;
      expected = ~exp_v;
      start    = 1'b0;
      for (int c = 0; c <= 131 && !stop; c++) begin
         for (int i = 0; i < 3; i++) begin
            int         s;
            int         len;
            bit         aborted;
            logic [2:0] ex_x;
            logic       ex_b;
            logic       ex_d;
            logic [7:0] ex_t;
            logic       ex_m;
            logic [2:0] ex_e;
            s       = settle_of(i);
            len     = 8 * (s + 1);
            aborted = (abort_at >= 0) && (c >= abort_at) && (abort_at <= len);
            ex_x = 3'd0;
            ex_b = 1'b0;
            ex_d = 1'b0;
            if (!aborted && c < len) begin
               ex_x = 3'(c / (s + 1));
               ex_b = 1'b1;
            end else if (!aborted && c == len) begin
               ex_d = 1'b1;
            end
            if (!aborted && c >= len) begin
               ex_t = new_tbl; ex_m = new_mm; ex_e = new_ei;
            end else begin
               ex_t = prev_tbl; ex_m = prev_mm; ex_e = prev_ei;
            end
            if ({xv[i], busy[i], done[i], tbl[i], mm[i], ei[i]} !==
                {ex_x, ex_b, ex_d, ex_t, ex_m, ex_e})
               bad[i]++;
            if (done[i] && done_at[i] < 0) done_at[i] = c;
         end
         if (c == rst_at) begin
            #2;
            rst_n = 1'b0;
            #1;
            check_reset_outputs("mid_reset");
            stop = 1'b1;
         end else begin
            abort = (abort_at >= 0) && (c == abort_at - 1);
            start = (rand_start && c < 14) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk);
            #1;
         end
      end
      abort = 1'b0;
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("seq_s%0d", settle_of(i)), 32'(bad[i]), 32'd0);
         if (rst_at < 0)
            check($sformatf("done_cycle_s%0d", settle_of(i)), 32'(done_at[i]),
                  (abort_at >= 0) ? 32'hFFFF_FFFF : 32'(8 * (settle_of(i) + 1)));
      end
      if (rst_at >= 0) begin
         @(negedge clk);
         rst_n    = 1'b1;
         prev_tbl = 8'h00;
         prev_mm  = 1'b0;
         prev_ei  = 3'd0;
      end else if (abort_at >= 0) begin
         check("abort_keeps_table", 32'(tbl[1]), 32'(prev_tbl));
      end else begin
         check("table_out", 32'(tbl[1]),  32'(new_tbl));
         check("mismatch",  32'(mm[1]),   32'(new_mm));
         check("err_index", 32'(ei[1]),   32'(new_ei));
         prev_tbl = new_tbl;
         prev_mm  = new_mm;
         prev_ei  = new_ei;
      end
   endtask

   // Start held high: done should recur every sweep + DONE + IDLE cycles.
   task automatic hold_start();
      int q0 [$];
      int q1 [$];
      @(negedge clk);
      expected = func_tbl;
      start    = 1'b1;
      for (int c = 0; c < 100; c++) begin
         @(posedge clk);
         #1;
         if (done[1]) q1.push_back(c);
         if (done[0]) q0.push_back(c);
      end
      start = 1'b0;
      repeat (140) @(posedge clk);
      #1;
      check("hold_count_s2", 32'(q1.size() >= 3), 32'd1);
      check("hold_count_s1", 32'(q0.size() >= 4), 32'd1);
      for (int k = 0; k + 1 < q1.size(); k++)
         check("hold_period_s2", 32'(q1[k+1] - q1[k]), 32'd26);
      for (int k = 0; k + 1 < q0.size(); k++)
         check("hold_period_s1", 32'(q0[k+1] - q0[k]), 32'd18);
      prev_tbl = func_tbl;
      prev_mm  = 1'b0;
      prev_ei  = 3'd0;
      check("hold_table", 32'(tbl[2]), 32'(func_tbl));
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      abort    = 1'b0;
      expected = 8'h00;
      func_tbl = 8'hEA;      // f = x1&x2 | x3
      prev_tbl = 8'h00;
      prev_mm  = 1'b0;
      prev_ei  = 3'd0;
      #13;
      check_reset_outputs("por");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // start with abort in IDLE must not begin a sweep
      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      check("start_with_abort", 32'(busy), 32'd0);

      sweep(8'hEA, -1, -1, 1'b0);
      sweep(8'hE8, -1, -1, 1'b0);
      sweep(8'hEA, 13, -1, 1'b0);
      sweep(8'hEA, -1, 15, 1'b0);
      sweep(8'hEA, -1, -1, 1'b0);
      hold_start();

      for (int r = 0; r < 6; r++) begin
         logic [7:0] e;
         func_tbl = 8'($urandom);
         e = ($urandom_range(0, 2) == 0) ? func_tbl : 8'($urandom);
         sweep(e, -1, -1, 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
